// File: rtl/led_panel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : led_panel_receiver
// Purpose  : Oversampling receiver for a two-colour LED scan interface; emits
//            each latched row as a one-cycle record with on-time and framing.
// Revision : 1.0 - initial release
// ============================================================================
module led_panel_receiver #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LIT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             green,
    input  logic             step,
    input  logic             latch,
    input  logic [3:0]       addr,
    input  logic             output_enable,
    input  logic             clr_err,
    output logic             row_valid,
    output logic [3:0]       row_addr,
    output logic [COLS-1:0]  row_red,
    output logic [COLS-1:0]  row_green,
    output logic [LIT_W-1:0] row_lit,
    output logic             frame_start,
    output logic             err_count
);

    localparam int                 c_CNT_W    = $clog2(COLS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(COLS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(COLS + 1);
    localparam logic [LIT_W-1:0]   c_LIT_MAX  = {LIT_W{1'b1}};
    localparam logic [3:0]         c_LAST_ROW = 4'(ROWS - 1);

    // All lines share one synchroniser chain so they stay mutually aligned.
    logic [8:0]         r_sync [SYNC_STAGES];
    logic               r_step_q, r_latch_q;
    logic [COLS-1:0]    r_sr_red, r_sr_green;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [LIT_W-1:0]   r_lit;
    logic [3:0]         r_prev_addr;
    logic               r_row_valid, r_frame_start, r_err;
    logic [3:0]         r_row_addr;
    logic [COLS-1:0]    r_row_red, r_row_green;
    logic [LIT_W-1:0]   r_row_lit;

    logic [8:0]         w_in, w_s;
    logic               w_s_red, w_s_green, w_s_step, w_s_latch, w_s_oe;
    logic [3:0]         w_s_addr;
    logic               w_step_rise, w_latch_rise;
    logic [COLS-1:0]    w_sr_red_nxt, w_sr_green_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    assign w_in = {red, green, step, latch, addr, output_enable};
    assign w_s  = r_sync[SYNC_STAGES-1];
    assign {w_s_red, w_s_green, w_s_step, w_s_latch, w_s_addr, w_s_oe} = w_s;

    assign w_step_rise  = w_s_step & ~r_step_q;
    assign w_latch_rise = w_s_latch & ~r_latch_q;

    // A step coinciding with the latch is folded into the snapshot and count.
    assign w_sr_red_nxt   = w_step_rise ? {r_sr_red[COLS-2:0], w_s_red} : r_sr_red;
    assign w_sr_green_nxt = w_step_rise ? {r_sr_green[COLS-2:0], w_s_green} : r_sr_green;
    assign w_cnt_nxt      = (w_step_rise && r_bit_cnt != c_CNT_SAT) ? r_bit_cnt + 1'b1 : r_bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_step_q      <= 1'b0;
            r_latch_q     <= 1'b0;
            r_sr_red      <= '0;
            r_sr_green    <= '0;
            r_bit_cnt     <= '0;
            r_lit         <= '0;
            r_prev_addr   <= '0;
            r_row_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
            r_row_addr    <= '0;
            r_row_red     <= '0;
            r_row_green   <= '0;
            r_row_lit     <= '0;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_step_q      <= w_s_step;
            r_latch_q     <= w_s_latch;
            r_sr_red      <= w_sr_red_nxt;
            r_sr_green    <= w_sr_green_nxt;
            r_row_valid   <= 1'b0;
            r_frame_start <= 1'b0;

            if (w_latch_rise) begin
                r_row_valid   <= 1'b1;
                r_row_addr    <= w_s_addr;
                r_row_red     <= w_sr_red_nxt;
                r_row_green   <= w_sr_green_nxt;
                r_row_lit     <= r_lit;
                r_frame_start <= (w_s_addr == 4'd0) && (r_prev_addr == c_LAST_ROW);
                r_prev_addr   <= w_s_addr;
                r_bit_cnt     <= {{(c_CNT_W-1){1'b0}}, w_step_rise};
                r_lit         <= {{(LIT_W-1){1'b0}}, w_s_oe};
            end else begin
                r_bit_cnt <= w_cnt_nxt;
                if (w_s_oe && r_lit != c_LIT_MAX) r_lit <= r_lit + 1'b1;
            end

            // A latch error outranks a simultaneous clear.
            if (w_latch_rise && w_cnt_nxt != c_CNT_FULL) r_err <= 1'b1;
            else if (clr_err)                            r_err <= 1'b0;
        end
    end

    assign row_valid   = r_row_valid;
    assign row_addr    = r_row_addr;
    assign row_red     = r_row_red;
    assign row_green   = r_row_green;
    assign row_lit     = r_row_lit;
    assign frame_start = r_frame_start;
    assign err_count   = r_err;

endmodule
`default_nettype wire
